// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: request-stage FSM encoding, AXI read
// constants shared with the memory-side requester, and reset/vector addresses.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ireq_state_e;

  localparam logic [3:0]  INST_ARID      = 4'd0;
  localparam logic [31:0] DEF_RESET_ADDR = 32'hbfc00000;
  localparam logic [31:0] DEF_EXC_ADDR   = 32'hbfc00380;

  // Single-beat, 4-byte bursts for every read on the shared AXI port.
  localparam logic [7:0]  AXI_ARLEN      = 8'd0;
  localparam logic [2:0]  AXI_ARSIZE     = 3'd2;

  // Force a byte address onto a word boundary for the AR channel.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    word_align = {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_req_stage_redirect_ctrl.sv
// Redirect bookkeeping for the instruction-request stage: prioritises
// exception/eret/branch redirects, remembers a branch until its delay slot
// has been issued, and tracks whether the in-flight request must be dropped.
module redirect_ctrl
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] EXC_ADDR = DEF_EXC_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  ireq_state_e state_i,
  input  logic [31:0] pc_i,
  input  logic        hs_i,
  input  logic        resp_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_pc_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_flush_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic        hard_o,
  output logic        redir_valid_o,
  output logic [31:0] redir_pc_o,
  output logic [31:0] next_pc_o,
  output logic        cancel_active_o
);

  logic        pending_br_q, pending_br_d;
  logic [31:0] br_slot_q, br_slot_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic        cancel_pending_q, cancel_pending_d;

  logic        br_late;
  logic        eff_pending;
  logic [31:0] eff_slot;
  logic [31:0] eff_tgt;
  logic        slot_hit;
  logic        cancel_set;

  // Redirect priority, next-PC selection and bookkeeping next-state.
  always_comb begin
    hard_o     = exc_flush_i | eret_i;
    br_late    = br_valid_i & ~hard_o & (pc_i == (br_pc_i + 32'd8));
    redir_valid_o = hard_o | br_late;
    if (exc_flush_i) begin
      redir_pc_o = EXC_ADDR;
    end else if (eret_i) begin
      redir_pc_o = epc_i;
    end else begin
      redir_pc_o = br_target_i;
    end

    // A branch resolving in the same cycle as the delay-slot issue must
    // still steer the PC that follows the slot.
    if (br_valid_i && !hard_o) begin
      eff_pending = 1'b1;
      eff_slot    = br_pc_i + 32'd4;
      eff_tgt     = br_target_i;
    end else begin
      eff_pending = pending_br_q;
      eff_slot    = br_slot_q;
      eff_tgt     = br_tgt_q;
    end
    slot_hit = eff_pending & (pc_i == eff_slot);
    if (slot_hit) begin
      next_pc_o = eff_tgt;
    end else begin
      next_pc_o = pc_i + 32'd4;
    end

    // Requests still in the AR phase die on any redirect; once accepted
    // only exception/eret kill them (a late branch in WAIT is the slot).
    cancel_set = ((state_i == ST_REQ) & redir_valid_o) |
                 ((state_i == ST_WAIT) & hard_o);
    cancel_active_o = cancel_pending_q | cancel_set;

    pending_br_d = pending_br_q;
    br_slot_d    = br_slot_q;
    br_tgt_d     = br_tgt_q;
    if (redir_valid_o) begin
      pending_br_d = 1'b0;
    end else if (hs_i && !cancel_active_o && slot_hit) begin
      pending_br_d = 1'b0;
    end else if (br_valid_i) begin
      pending_br_d = 1'b1;
      br_slot_d    = br_pc_i + 32'd4;
      br_tgt_d     = br_target_i;
    end else begin
      pending_br_d = pending_br_q;
    end

    if (resp_i) begin
      cancel_pending_d = 1'b0;
    end else if (cancel_set) begin
      cancel_pending_d = 1'b1;
    end else begin
      cancel_pending_d = cancel_pending_q;
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_br_q     <= 1'b0;
      br_slot_q        <= 32'd0;
      br_tgt_q         <= 32'd0;
      cancel_pending_q <= 1'b0;
    end else begin
      pending_br_q     <= pending_br_d;
      br_slot_q        <= br_slot_d;
      br_tgt_q         <= br_tgt_d;
      cancel_pending_q <= cancel_pending_d;
    end
  end

endmodule

// File: rtl/inst_req_stage.sv
// Instruction-request stage: owns the fetch PC, issues one AXI AR request
// at a time and presents PC_buffer/PC_AdEL/DSI_ID to fetch_stage.
module inst_req_stage
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEF_RESET_ADDR,
  parameter logic [31:0] EXC_ADDR   = DEF_EXC_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IRWrite,
  input  logic        IR_buffer_valid,
  input  logic [1:0]  data_r_req,
  output logic        fetch_axi_arvalid,
  output logic [31:0] fetch_axi_araddr,
  output logic [3:0]  fetch_axi_arid,
  input  logic        fetch_axi_arready,
  input  logic        fetch_axi_rvalid,
  input  logic        fetch_axi_rready,
  input  logic [3:0]  fetch_axi_rid,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  input  logic        is_branch_ID,
  input  logic        exc_flush,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] PC_buffer,
  output logic        PC_AdEL,
  output logic        DSI_ID,
  output logic        fetch_cancel
);

  ireq_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] issue_pc_q, issue_pc_d;
  logic        dsi_issue_q, dsi_issue_d;
  logic [31:0] pc_buffer_q, pc_buffer_d;
  logic        adel_q, adel_d;
  logic        dsi_q, dsi_d;
  logic        arvalid_q, arvalid_d;

  logic        inst_resp;
  logic        hs;
  logic        resp_wait;
  logic        start_req;
  logic        hard;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [31:0] next_pc;
  logic        cancel_active;

  assign inst_resp = fetch_axi_rvalid & fetch_axi_rready & (fetch_axi_rid == INST_ARID);
  assign hs        = (state_q == ST_REQ) & arvalid_q & fetch_axi_arready;
  assign resp_wait = (state_q == ST_WAIT) & inst_resp;

  redirect_ctrl #(
    .EXC_ADDR (EXC_ADDR)
  ) u_redirect_ctrl (
    .clk             (clk),
    .rst             (rst),
    .state_i         (state_q),
    .pc_i            (pc_q),
    .hs_i            (hs),
    .resp_i          (resp_wait),
    .br_valid_i      (br_valid),
    .br_pc_i         (br_pc),
    .br_target_i     (br_target),
    .exc_flush_i     (exc_flush),
    .eret_i          (eret),
    .epc_i           (epc),
    .hard_o          (hard),
    .redir_valid_o   (redir_valid),
    .redir_pc_o      (redir_pc),
    .next_pc_o       (next_pc),
    .cancel_active_o (cancel_active)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d   = state_q;
    start_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (IRWrite && !IR_buffer_valid && (data_r_req == 2'd0)) begin
          state_d   = ST_REQ;
          start_req = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (hs) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (resp_wait && (cancel_active || (data_r_req == 2'd0))) begin
          state_d = ST_IDLE;
        end else if (resp_wait) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (hard || !IR_buffer_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs and datapath next-state.
  always_comb begin
    arvalid_d    = (state_d == ST_REQ);
    fetch_cancel = (resp_wait & cancel_active) | ((state_q == ST_HOLD) & hard);

    if (redir_valid) begin
      pc_d = redir_pc;
    end else if (hs && !cancel_active) begin
      pc_d = next_pc;
    end else begin
      pc_d = pc_q;
    end

    if (start_req) begin
      issue_pc_d  = pc_d;
      dsi_issue_d = is_branch_ID;
    end else begin
      issue_pc_d  = issue_pc_q;
      dsi_issue_d = dsi_issue_q;
    end

    if (hs) begin
      pc_buffer_d = issue_pc_q;
      adel_d      = |issue_pc_q[1:0];
      dsi_d       = dsi_issue_q;
    end else begin
      pc_buffer_d = pc_buffer_q;
      adel_d      = adel_q;
      dsi_d       = dsi_q;
    end
  end

  // Datapath and registered output state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_ADDR;
      issue_pc_q  <= RESET_ADDR;
      dsi_issue_q <= 1'b0;
      pc_buffer_q <= RESET_ADDR;
      adel_q      <= 1'b0;
      dsi_q       <= 1'b0;
      arvalid_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      issue_pc_q  <= issue_pc_d;
      dsi_issue_q <= dsi_issue_d;
      pc_buffer_q <= pc_buffer_d;
      adel_q      <= adel_d;
      dsi_q       <= dsi_d;
      arvalid_q   <= arvalid_d;
    end
  end

  assign fetch_axi_arvalid = arvalid_q;
  assign fetch_axi_araddr  = word_align(issue_pc_q);
  assign fetch_axi_arid    = INST_ARID;
  assign PC_buffer         = pc_buffer_q;
  assign PC_AdEL           = adel_q;
  assign DSI_ID            = dsi_q;

endmodule

// File: tb/tb_inst_req_stage.sv
// Directed bench for inst_req_stage: drives AR/R handshakes by hand and
// checks issued addresses, PC_buffer flags and fetch_cancel.
module tb_inst_req_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IRWrite = 1'b0;
  logic        IR_buffer_valid = 1'b0;
  logic [1:0]  data_r_req = 2'd0;
  logic        fetch_axi_arvalid;
  logic [31:0] fetch_axi_araddr;
  logic [3:0]  fetch_axi_arid;
  logic        fetch_axi_arready = 1'b0;
  logic        fetch_axi_rvalid = 1'b0;
  logic        fetch_axi_rready = 1'b0;
  logic [3:0]  fetch_axi_rid = 4'd0;
  logic        br_valid = 1'b0;
  logic [31:0] br_pc = 32'd0;
  logic [31:0] br_target = 32'd0;
  logic        is_branch_ID = 1'b0;
  logic        exc_flush = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = 32'd0;
  logic [31:0] PC_buffer;
  logic        PC_AdEL;
  logic        DSI_ID;
  logic        fetch_cancel;

  int n_vec = 0;
  int n_err = 0;

  inst_req_stage dut (
    .clk               (clk),
    .rst               (rst),
    .IRWrite           (IRWrite),
    .IR_buffer_valid   (IR_buffer_valid),
    .data_r_req        (data_r_req),
    .fetch_axi_arvalid (fetch_axi_arvalid),
    .fetch_axi_araddr  (fetch_axi_araddr),
    .fetch_axi_arid    (fetch_axi_arid),
    .fetch_axi_arready (fetch_axi_arready),
    .fetch_axi_rvalid  (fetch_axi_rvalid),
    .fetch_axi_rready  (fetch_axi_rready),
    .fetch_axi_rid     (fetch_axi_rid),
    .br_valid          (br_valid),
    .br_pc             (br_pc),
    .br_target         (br_target),
    .is_branch_ID      (is_branch_ID),
    .exc_flush         (exc_flush),
    .eret              (eret),
    .epc               (epc),
    .PC_buffer         (PC_buffer),
    .PC_AdEL           (PC_AdEL),
    .DSI_ID            (DSI_ID),
    .fetch_cancel      (fetch_cancel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for AR valid, then check the request it presents.
  task automatic wait_ar(input logic [31:0] exp_addr);
    int k = 0;
    while (!fetch_axi_arvalid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("arvalid", {31'd0, fetch_axi_arvalid}, 32'd1);
    chk("araddr", fetch_axi_araddr, exp_addr);
    chk("arid", {28'd0, fetch_axi_arid}, 32'd0);
  endtask

  // One-cycle AR handshake, then check the buffered PC information.
  task automatic do_hs(input logic [31:0] exp_pc, input logic exp_adel, input logic exp_dsi);
    fetch_axi_arready = 1'b1;
    @(negedge clk);
    fetch_axi_arready = 1'b0;
    chk("pc_buffer", PC_buffer, exp_pc);
    chk("pc_adel", {31'd0, PC_AdEL}, {31'd0, exp_adel});
    chk("dsi_id", {31'd0, DSI_ID}, {31'd0, exp_dsi});
    chk("arvalid_after_hs", {31'd0, fetch_axi_arvalid}, 32'd0);
  endtask

  // One-cycle R beat with rid 0; fetch_cancel is checked during the beat.
  task automatic do_resp(input logic [1:0] drr, input logic exp_cancel);
    data_r_req       = drr;
    fetch_axi_rvalid = 1'b1;
    fetch_axi_rready = 1'b1;
    fetch_axi_rid    = 4'd0;
    #1;
    chk("fetch_cancel_resp", {31'd0, fetch_cancel}, {31'd0, exp_cancel});
    @(negedge clk);
    fetch_axi_rvalid = 1'b0;
    fetch_axi_rready = 1'b0;
    data_r_req       = 2'd0;
  endtask

  initial begin
    // Reset state.
    IRWrite = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc_buffer", PC_buffer, 32'hbfc00000);
    chk("rst_adel", {31'd0, PC_AdEL}, 32'd0);
    chk("rst_dsi", {31'd0, DSI_ID}, 32'd0);
    chk("rst_arvalid", {31'd0, fetch_axi_arvalid}, 32'd0);
    chk("rst_cancel", {31'd0, fetch_cancel}, 32'd0);
    rst = 1'b1;

    // Sequential fetch from the reset vector.
    wait_ar(32'hbfc00000);
    do_hs(32'hbfc00000, 1'b0, 1'b0);
    do_resp(2'd0, 1'b0);
    wait_ar(32'hbfc00004);
    do_hs(32'hbfc00004, 1'b0, 1'b0);
    // A beat for a different id must not complete the instruction request.
    fetch_axi_rvalid = 1'b1;
    fetch_axi_rready = 1'b1;
    fetch_axi_rid    = 4'd1;
    #1;
    chk("rid1_cancel", {31'd0, fetch_cancel}, 32'd0);
    @(negedge clk);
    fetch_axi_rvalid = 1'b0;
    fetch_axi_rready = 1'b0;
    fetch_axi_rid    = 4'd0;
    chk("rid1_arvalid_a", {31'd0, fetch_axi_arvalid}, 32'd0);
    @(negedge clk);
    chk("rid1_arvalid_b", {31'd0, fetch_axi_arvalid}, 32'd0);
    do_resp(2'd0, 1'b0);

    // Branch at bfc00010 -> bfc00100 resolved before its delay slot issues.
    for (int i = 2; i < 5; i++) begin
      wait_ar(32'hbfc00000 + 32'(i) * 32'd4);
      do_hs(32'hbfc00000 + 32'(i) * 32'd4, 1'b0, 1'b0);
      do_resp(2'd0, 1'b0);
    end
    is_branch_ID = 1'b1;
    wait_ar(32'hbfc00014);
    br_valid  = 1'b1;
    br_pc     = 32'hbfc00010;
    br_target = 32'hbfc00100;
    @(negedge clk);
    br_valid = 1'b0;
    do_hs(32'hbfc00014, 1'b0, 1'b1);
    is_branch_ID = 1'b0;
    do_resp(2'd0, 1'b0);
    wait_ar(32'hbfc00100);
    do_hs(32'hbfc00100, 1'b0, 1'b0);
    do_resp(2'd0, 1'b0);

    // Response lands in IR_buffer -> HOLD; exception while holding.
    wait_ar(32'hbfc00104);
    do_hs(32'hbfc00104, 1'b0, 1'b0);
    IR_buffer_valid = 1'b1;
    do_resp(2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_arvalid", {31'd0, fetch_axi_arvalid}, 32'd0);
    end
    exc_flush = 1'b1;
    #1;
    chk("hold_exc_cancel", {31'd0, fetch_cancel}, 32'd1);
    @(negedge clk);
    exc_flush       = 1'b0;
    IR_buffer_valid = 1'b0;
    #1;
    chk("hold_exc_cancel_end", {31'd0, fetch_cancel}, 32'd0);
    wait_ar(32'hbfc00380);
    do_hs(32'hbfc00380, 1'b0, 1'b0);

    // HOLD released by IR_buffer_valid falling.
    IR_buffer_valid = 1'b1;
    do_resp(2'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold2_arvalid", {31'd0, fetch_axi_arvalid}, 32'd0);
    end
    IR_buffer_valid = 1'b0;
    wait_ar(32'hbfc00384);
    do_hs(32'hbfc00384, 1'b0, 1'b0);

    // eret to a misaligned epc while waiting: word dropped, aligned reissue.
    eret = 1'b1;
    epc  = 32'hbfc00102;
    @(negedge clk);
    eret = 1'b0;
    do_resp(2'd0, 1'b1);
    wait_ar(32'hbfc00100);
    do_hs(32'hbfc00102, 1'b1, 1'b0);
    do_resp(2'd0, 1'b0);
    wait_ar(32'hbfc00104);
    do_hs(32'hbfc00106, 1'b1, 1'b0);
    do_resp(2'd0, 1'b0);

    // Reset while a request is pending abandons it.
    wait_ar(32'hbfc00108);
    rst = 1'b0;
    #1;
    chk("midreq_rst_arvalid", {31'd0, fetch_axi_arvalid}, 32'd0);
    chk("midreq_rst_pc_buffer", PC_buffer, 32'hbfc00000);
    chk("midreq_rst_adel", {31'd0, PC_AdEL}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Branch at bfc00010 resolved while bfc00018 sits un-accepted on AR.
    for (int i = 0; i < 6; i++) begin
      wait_ar(32'hbfc00000 + 32'(i) * 32'd4);
      do_hs(32'hbfc00000 + 32'(i) * 32'd4, 1'b0, 1'b0);
      do_resp(2'd0, 1'b0);
    end
    wait_ar(32'hbfc00018);
    br_pc     = 32'hbfc00010;
    br_target = 32'hbfc00100;
    for (int i = 0; i < 5; i++) begin
      br_valid = (i == 1);
      @(negedge clk);
      chk("stall_arvalid", {31'd0, fetch_axi_arvalid}, 32'd1);
      chk("stall_araddr", fetch_axi_araddr, 32'hbfc00018);
    end
    br_valid = 1'b0;
    do_hs(32'hbfc00018, 1'b0, 1'b0);
    do_resp(2'd0, 1'b1);
    wait_ar(32'hbfc00100);
    do_hs(32'hbfc00100, 1'b0, 1'b0);
    do_resp(2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
